uart_tx_fifo: RTL and testbench

Byte FIFO between the design's byte producers (memory readback, echo logic) and `uart_tx`. Accepts bytes on a valid/ready port and drains them into `uart_tx` through its `data_we`/`data`/`data_wait` handshake. This removes the one-byte-in-flight limit of driving `uart_tx` directly. Single clock domain, same clock as `uart_tx`.

---
 rtl/uart_tx_fifo.sv | 121 ++++++++++++
 tb/tb_uart_tx_fifo.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_fifo
//  Purpose  : Byte FIFO between byte producers and uart_tx. Accepts bytes on
//             a valid/ready port and presents the head byte to uart_tx via
//             its data_we / data / data_wait handshake.
//  Ports    : clk        - system clock, rising-edge
//             reset      - asynchronous active-high reset
//             in_data    - byte to enqueue
//             in_valid   - producer offers in_data
//             in_ready   - !full; push when in_valid && in_ready
//             tx_data    - head byte (8'h00 when empty)
//             tx_we      - !empty; to uart_tx.data_we
//             tx_wait    - uart_tx.data_wait; high = byte not taken
//             level      - occupancy 0..2^DEPTH_LOG2
//             empty/full - occupancy flags
//             drop_count - saturating count of cycles with in_valid && full
//                          (only with UART_TX_FIFO_DROP_CNT_EN defined)
//  Options  : `define UART_TX_FIFO_DROP_CNT_EN adds the drop_count port.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [7:0]            tx_data,
  output logic                  tx_we,
  input  logic                  tx_wait,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  empty,
  output logic                  full
`ifdef UART_TX_FIFO_DROP_CNT_EN
  ,
  output logic [7:0]            drop_count
`endif
);

  localparam int                DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] C_DEPTH = (DEPTH_LOG2+1)'(DEPTH);

  // Storage is deliberately not reset; only the pointers define validity.
  logic [7:0]            mem_q [DEPTH];

  // Pointers carry one extra MSB so full and empty are distinguishable.
  logic [DEPTH_LOG2:0]   wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0]   rd_ptr_q, rd_ptr_d;

  logic                  push;
  logic                  pop;

  // All status outputs decode from registered pointers only.
  assign level    = wr_ptr_q - rd_ptr_q;
  assign empty    = (level == '0);
  assign full     = (level == C_DEPTH);
  assign in_ready = !full;
  assign tx_we    = !empty;

  assign push = in_valid && !full;
  assign pop  = tx_we && !tx_wait;

  always_comb begin
    tx_data = 8'h00;
    if (!empty) begin
      tx_data = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= in_data;
    end
  end

`ifdef UART_TX_FIFO_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (in_valid && full && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_cnt_q <= 8'h00;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_count = drop_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_fifo
//  Purpose  : Directed self-checking bench for uart_tx_fifo (DEPTH_LOG2 = 4).
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_tx_fifo;

    logic       clk;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] tx_data;
    logic       tx_we;
    logic       tx_wait;
    logic [4:0] level;
    logic       empty;
    logic       full;
`ifdef UART_TX_FIFO_DROP_CNT_EN
    logic [7:0] drop_count;
`endif

    int n_total = 0;
    int n_pass  = 0;
    bit clk_run = 0;

    uart_tx_fifo #(.DEPTH_LOG2(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .tx_data  (tx_data),
        .tx_we    (tx_we),
        .tx_wait  (tx_wait),
        .level    (level),
        .empty    (empty),
        .full     (full)
`ifdef UART_TX_FIFO_DROP_CNT_EN
        ,
        .drop_count (drop_count)
`endif
    );

    initial begin
        clk = 1'b0;
        wait (clk_run);
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input bit ok,
                       input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (ok) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        in_data  = 8'h00;
        in_valid = 1'b0;
        tx_wait  = 1'b0;

        // Reset values with no clock running.
        #2;
        chk("rst_empty",    empty    === 1'b1,  empty,    1'b1);
        chk("rst_full",     full     === 1'b0,  full,     1'b0);
        chk("rst_level",    level    === 5'd0,  level,    5'd0);
        chk("rst_in_ready", in_ready === 1'b1,  in_ready, 1'b1);
        chk("rst_tx_we",    tx_we    === 1'b0,  tx_we,    1'b0);
        chk("rst_tx_data",  tx_data  === 8'h00, tx_data,  8'h00);
`ifdef UART_TX_FIFO_DROP_CNT_EN
        chk("rst_drop",     drop_count === 8'h00, drop_count, 8'h00);
`endif

        clk_run = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // Single byte: pushed at one edge, popped at the next.
        in_data  = 8'h41;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("single_tx_we",    tx_we   === 1'b1,  tx_we,   1'b1);
        chk("single_tx_data",  tx_data === 8'h41, tx_data, 8'h41);
        chk("single_level",    level   === 5'd1,  level,   5'd1);
        tick();
        chk("single_empty",    empty   === 1'b1,  empty,   1'b1);
        chk("single_tx_data0", tx_data === 8'h00, tx_data, 8'h00);

        // Fill with 00..0F while the transmitter is busy.
        tx_wait = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_data  = 8'(i);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        chk("fill_full",     full     === 1'b1,  full,     1'b1);
        chk("fill_level",    level    === 5'd16, level,    5'd16);
        chk("fill_in_ready", in_ready === 1'b0,  in_ready, 1'b0);
        chk("fill_head",     tx_data  === 8'h00, tx_data,  8'h00);

        // Drop while full.
        in_data  = 8'hAA;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("drop_level", level   === 5'd16, level,   5'd16);
        chk("drop_head",  tx_data === 8'h00, tx_data, 8'h00);
`ifdef UART_TX_FIFO_DROP_CNT_EN
        chk("drop_count", drop_count === 8'h01, drop_count, 8'h01);
`endif

        // Push offered in the same cycle as a pop while full: rejected.
        in_data  = 8'hBB;
        in_valid = 1'b1;
        tx_wait  = 1'b0;
        tick();
        in_valid = 1'b0;
        tx_wait  = 1'b1;
        chk("fullpop_level", level   === 5'd15, level,   5'd15);
        chk("fullpop_head",  tx_data === 8'h01, tx_data, 8'h01);
        tick();
        chk("wait_hold_head",  tx_data === 8'h01, tx_data, 8'h01);
        chk("wait_hold_tx_we", tx_we   === 1'b1,  tx_we,   1'b1);

        // Drain: remaining bytes leave in order, and neither AA nor BB appears.
        tx_wait = 1'b0;
        for (int i = 1; i < 16; i++) begin
            chk("drain_order", tx_data === 8'(i), tx_data, 8'(i));
            tick();
        end
        chk("drain_empty",   empty   === 1'b1,  empty,   1'b1);
        chk("drain_tx_data", tx_data === 8'h00, tx_data, 8'h00);

        // Steady state at level 5 across pointer wraps.
        tx_wait = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data  = 8'h50 + 8'(i);
            in_valid = 1'b1;
            tick();
        end
        chk("steady_pre_level", level === 5'd5, level, 5'd5);
        tx_wait = 1'b0;
        for (int k = 0; k < 40; k++) begin
            logic [7:0] w_exp;
            w_exp   = (k < 5) ? 8'h50 + 8'(k) : 8'h60 + 8'(k - 5);
            in_data = 8'h60 + 8'(k);
            chk("steady_order", tx_data === w_exp, tx_data, w_exp);
            tick();
            chk("steady_level", level === 5'd5, level, 5'd5);
        end
        in_valid = 1'b0;
        tx_wait  = 1'b1;
        // Head is the byte pushed at k = 35.
        chk("steady_head", tx_data === 8'h83, tx_data, 8'h83);

        // Reach level 7, then reset between clock edges.
        in_data  = 8'hE0;
        in_valid = 1'b1;
        tick();
        in_data  = 8'hE1;
        tick();
        in_valid = 1'b0;
        chk("mid_pre_level", level === 5'd7, level, 5'd7);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_empty",    empty    === 1'b1,  empty,    1'b1);
        chk("mid_level",    level    === 5'd0,  level,    5'd0);
        chk("mid_tx_we",    tx_we    === 1'b0,  tx_we,    1'b0);
        chk("mid_tx_data",  tx_data  === 8'h00, tx_data,  8'h00);
        chk("mid_in_ready", in_ready === 1'b1,  in_ready, 1'b1);
        chk("mid_full",     full     === 1'b0,  full,     1'b0);
`ifdef UART_TX_FIFO_DROP_CNT_EN
        chk("mid_drop",     drop_count === 8'h00, drop_count, 8'h00);
`endif
        tick();
        tick();
        reset   = 1'b0;
        tx_wait = 1'b0;

        // Only a byte pushed after reset is transmitted.
        in_data  = 8'hC3;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("post_rst_level", level   === 5'd1,  level,   5'd1);
        chk("post_rst_head",  tx_data === 8'hC3, tx_data, 8'hC3);
        tick();
        chk("post_rst_empty", empty   === 1'b1,  empty,   1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
